// File: rtl/axi_pkg.sv
// Shared AXI widths, encodings and arbiter state type used by the AR/AW arbiters.
package axi_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Upper nibble of the slave-side ID; the R router uses it to pick the master.
  localparam logic [3:0] MTAG_M0 = 4'd0;
  localparam logic [3:0] MTAG_M1 = 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCK
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Two-request round-robin pick plus pointer update on a completed grant.
module rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  input  logic       granted,
  output logic       grant,
  output logic       ptr_next
);

  always_comb begin
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ptr;
    endcase
    // The pointer flips away from whoever was served, even if it was the only requester.
    ptr_next = advance ? ~granted : ptr;
  end

endmodule

// File: rtl/ar_arbiter_rr.sv
// Round-robin arbiter for the shared AR channel; holds the channel locked until RLAST.
module ar_arbiter_rr
  import axi_pkg::*;
#(
  parameter int unsigned ID_BITS   = AXI_ID_BITS,
  parameter int unsigned IDS_BITS  = AXI_IDS_BITS,
  parameter int unsigned ADDR_BITS = AXI_ADDR_BITS,
  parameter int unsigned LEN_BITS  = AXI_LEN_BITS,
  parameter int unsigned SIZE_BITS = AXI_SIZE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]           ARBURST_M0,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M0,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M0,
  output logic                 ARREADY_M1,
  input  logic                 ARREADY,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 RLAST,
  output logic [IDS_BITS-1:0]  ARIDS,
  output logic [ADDR_BITS-1:0] ARADDR,
  output logic [LEN_BITS-1:0]  ARLEN,
  output logic [SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  output logic                 AR_IDLE,
  output logic                 AR_LOCK,
  output logic                 GRANT_M1
);

  arb_state_e           state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 grant_q, grant_d;
  logic [ADDR_BITS-1:0] araddr_q, araddr_d;

  logic                 pick;
  logic                 ar_hs;
  logic [ID_BITS-1:0]   sel_id;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [LEN_BITS-1:0]  sel_len;
  logic [SIZE_BITS-1:0] sel_size;
  logic [1:0]           sel_burst;
  logic                 sel_valid;
  logic [3:0]           sel_tag;

  assign sel_id    = grant_q ? ARID_M1    : ARID_M0;
  assign sel_addr  = grant_q ? ARADDR_M1  : ARADDR_M0;
  assign sel_len   = grant_q ? ARLEN_M1   : ARLEN_M0;
  assign sel_size  = grant_q ? ARSIZE_M1  : ARSIZE_M0;
  assign sel_burst = grant_q ? ARBURST_M1 : ARBURST_M0;
  assign sel_valid = grant_q ? ARVALID_M1 : ARVALID_M0;
  assign sel_tag   = grant_q ? MTAG_M1    : MTAG_M0;

  assign ar_hs = (state_q == GRANT) && sel_valid && ARREADY;

  rr_picker u_picker (
    .req      ({ARVALID_M1, ARVALID_M0}),
    .ptr      (rr_ptr_q),
    .advance  (ar_hs),
    .granted  (grant_q),
    .grant    (pick),
    .ptr_next (rr_ptr_d)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    araddr_d = araddr_q;
    case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The other master is ignored here; AXI forbids withdrawing ARVALID.
        if (ar_hs) begin
          araddr_d = sel_addr;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        if (RVALID && RREADY && RLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ARIDS      = '0;
    ARADDR     = araddr_q;
    ARLEN      = '0;
    ARSIZE     = '0;
    ARBURST    = '0;
    ARVALID    = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    if (state_q == GRANT) begin
      ARIDS      = IDS_BITS'({sel_tag, sel_id});
      ARADDR     = sel_addr;
      ARLEN      = sel_len;
      ARSIZE     = sel_size;
      ARBURST    = sel_burst;
      ARVALID    = sel_valid;
      ARREADY_M0 = ARREADY & ~grant_q;
      ARREADY_M1 = ARREADY & grant_q;
    end
    AR_IDLE  = (state_q == IDLE);
    AR_LOCK  = (state_q == LOCK);
    GRANT_M1 = grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
    end
  end

endmodule

// File: doc/ar_arbiter_rr.md
Name: ar_arbiter_rr

Overview:
- Two-master round-robin arbiter for the shared AXI read-address (AR) channel. M0 is the instruction fetch port and M1 is the data port.
- Grants one master and forwards its AR fields to the AR decoder. Once the address is accepted, the channel stays locked until the read burst finishes (R handshake with RLAST).
- Extends each ID to an IDS tag so the R-channel router can return data to the correct master.

Parameters:
- ID_BITS, 4, master-side ID width
- IDS_BITS, 8, slave-side ID width = 4-bit master tag + ID_BITS
- ADDR_BITS, 32, address width
- LEN_BITS, 4, burst length width
- SIZE_BITS, 3, burst size width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ARID_M0 / ARID_M1  in  ID_BITS  master read IDs
- ARADDR_M0 / ARADDR_M1  in  ADDR_BITS  addresses
- ARLEN_M0 / ARLEN_M1  in  LEN_BITS  burst lengths
- ARSIZE_M0 / ARSIZE_M1  in  SIZE_BITS  burst sizes
- ARBURST_M0 / ARBURST_M1  in  2  burst types
- ARVALID_M0 / ARVALID_M1  in  1  requests
- ARREADY_M0 / ARREADY_M1  out  1  per-master accept
- ARREADY  in  1  accept from AR decoder
- RVALID, RREADY, RLAST  in  1 each  R-channel observation for lock release
- ARIDS  out  IDS_BITS  {4'(grant index), granted ARID}
- ARADDR  out  ADDR_BITS; ARLEN  out  LEN_BITS; ARSIZE  out  SIZE_BITS; ARBURST  out  2  forwarded fields
- ARVALID  out  1  forwarded request
- AR_IDLE  out  1  arbiter in IDLE
- AR_LOCK  out  1  burst outstanding
- GRANT_M1  out  1  0 = M0 granted, 1 = M1 granted

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - state=IDLE, rr_ptr=0 (M0 preferred), grant_reg=0.
  - All outputs 0 except AR_IDLE=1.
  - ARADDR_reg=0; ARADDR shows ARADDR_reg outside GRANT.
- States: IDLE, GRANT, LOCK.
- IDLE:
  - No request: stay in IDLE.
  - One master requesting: grant_reg <= that master, go to GRANT.
  - Both requesting: grant_reg <= rr_ptr, go to GRANT.
  - Outputs: ARVALID=0, ARREADY_Mx=0, AR_IDLE=1.
- GRANT:
  - Forward the granted master's fields, with ARVALID = ARVALID_Mgrant.
  - ARREADY_Mgrant = ARREADY; the other master's ARREADY = 0.
  - ARVALID && ARREADY: go to LOCK, latch ARADDR_reg, rr_ptr <= ~grant_reg.
  - Otherwise hold GRANT. Requests from the other master are ignored; AXI forbids ARVALID withdrawal, so no timeout.
- LOCK:
  - ARVALID=0, ARREADY_M0=ARREADY_M1=0, AR_LOCK=1, other fields 0.
  - RVALID && RREADY && RLAST: go to IDLE.
  - A non-last beat does not release the lock.
- Latency:
  - Request seen in IDLE at cycle n: ARVALID=1 at n+1.
  - Earliest next grant: the cycle after the RLAST handshake, plus 1.
- Fairness: under continuous requests from both masters, grants alternate M0, M1, M0, ... After a single-requester grant, rr_ptr still flips.
- Simultaneous events:
  - The RLAST handshake and a new request in the same LOCK cycle cause no grant that cycle; the new request is evaluated in IDLE.
  - An AR handshake in the first GRANT cycle is legal.
- Combinational paths: ARREADY_Mx and ARVALID are combinational from the inputs during GRANT. No combinational path from ARVALID_Mx to ARREADY_Mx.
- Reset mid-burst: returns to IDLE immediately. The R router is reset by the same rst.

Decomposition:
- Shared axi_pkg holds:
  - widths (AXI_ID_BITS, AXI_IDS_BITS, AXI_ADDR_BITS, AXI_LEN_BITS, AXI_SIZE_BITS)
  - burst/resp constants
  - arb_state_e enum {IDLE, GRANT, LOCK}, reused by the AW arbiter
  - master tag constants MTAG_M0=4'd0, MTAG_M1=4'd1
- One sub-module, rr_picker: 2-request round-robin pointer logic (req[1:0], ptr in, advance strobe, grant index out).

Test Plan:
- Reset release with no requests: AR_IDLE=1, ARVALID=0 indefinitely, ARADDR=0.
- Only M1 requests (ARADDR_M1=0x1000_0040, ARID_M1=3, ARLEN=3), ARREADY=1 in GRANT:
  - ARVALID=1 one cycle after the request, ARIDS=8'h13, ARREADY_M1=1, ARREADY_M0=0.
  - LOCK holds through 3 non-last beats; IDLE follows the 4th beat with RLAST.
- Both masters request continuously, 1-beat bursts: grants go M0, M1, M0, M1, with GRANT_M1 = 0, 1, 0, 1 across transactions.
- In GRANT with ARREADY held 0 for 5 cycles: ARVALID stays 1 and the fields stay stable. M0 asserting mid-wait gets no grant. Handshake on cycle 6 moves to LOCK.
- In LOCK, RVALID=1, RREADY=0, RLAST=1 for 3 cycles: stays in LOCK. RREADY=1 then goes to IDLE the next cycle.
- rst asserted asynchronously during LOCK (mid-burst): outputs return to reset values immediately. After release, a fresh M0 request is granted and rr_ptr starts at M0.
